des3_wb_regs: RTL and testbench

DES3_WB_REGS -- requirements
Module: des3_wb_regs

---
 rtl/des3_wb_pkg.sv | 27 ++
 rtl/des3_wb_decode.sv | 65 ++++++
 rtl/des3_wb_regs.sv | 164 ++++++++++++++++
 tb/tb_des3_wb_regs.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/des3_wb_pkg.sv
// Shared register map, bit positions and FSM encoding for the DES3 Wishbone register block.
package des3_wb_pkg;

  localparam logic [3:0] IDX_CTRL    = 4'd0;
  localparam logic [3:0] IDX_STATUS  = 4'd1;
  localparam logic [3:0] IDX_KEY0    = 4'd2;
  localparam logic [3:0] IDX_DIN_HI  = 4'd8;
  localparam logic [3:0] IDX_DOUT_HI = 4'd10;
  localparam logic [3:0] IDX_DOUT_LO = 4'd11;

  localparam int CTRL_START   = 0;
  localparam int CTRL_DECRYPT = 1;
  localparam int CTRL_IE      = 2;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_TIMEOUT = 2;

  localparam int CORE_LAT_DEF = 48;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/des3_wb_decode.sv
// Combinational word-index decode: per-register write enables, byte mask, read mux, error flag.
module des3_wb_decode
  import des3_wb_pkg::*;
(
  input  logic [3:0]   idx,
  input  logic [3:0]   sel,
  input  logic         req,
  input  logic         we,
  input  logic         busy,
  input  logic [31:0]  ctrl_rd,
  input  logic [31:0]  status_rd,
  input  logic [191:0] key,
  input  logic [63:0]  din,
  input  logic [63:0]  dout,
  output logic         wr_ctrl,
  output logic         wr_status,
  output logic [5:0]   wr_key,
  output logic [1:0]   wr_din,
  output logic [31:0]  wmask,
  output logic         err,
  output logic [31:0]  rd_data
);

  // Configuration writes are acknowledged but discarded while the core runs.
  logic wr_cfg;
  assign wr_cfg = req & we & ~busy;

  always_comb begin
    wr_ctrl   = 1'b0;
    wr_status = 1'b0;
    wr_key    = '0;
    wr_din    = '0;
    err       = 1'b0;
    rd_data   = '0;
    wmask     = '0;
    for (int b = 0; b < 4; b++) wmask[8*b +: 8] = {8{sel[b]}};

    if (idx == IDX_CTRL) begin
      rd_data = ctrl_rd;
      wr_ctrl = wr_cfg;
    end
    if (idx == IDX_STATUS) begin
      rd_data   = status_rd;
      wr_status = req & we;
    end
    for (int i = 0; i < 6; i++) begin
      if (idx == IDX_KEY0 + 4'(i)) begin
        rd_data   = key[191-32*i -: 32];
        wr_key[i] = wr_cfg;
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (idx == IDX_DIN_HI + 4'(i)) begin
        rd_data   = din[63-32*i -: 32];
        wr_din[i] = wr_cfg;
      end
      if (idx == IDX_DOUT_HI + 4'(i)) begin
        rd_data = dout[63-32*i -: 32];
        err     = we;
      end
    end
    if (idx > IDX_DOUT_LO) err = 1'b1;
  end

endmodule

// File: rtl/des3_wb_regs.sv
// Wishbone register front-end and run/watchdog FSM for a DES3 core.
// Optional macro DES3_WB_REGS_INT_EN enables the CTRL.ie bit and the registered int_o.
module des3_wb_regs
  import des3_wb_pkg::*;
#(
  parameter int AW       = 30,
  parameter int DW       = 32,
  parameter int CORE_LAT = CORE_LAT_DEF
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  input  logic [AW-1:0]  wb_adr_i,
  input  logic [DW-1:0]  wb_dat_i,
  input  logic [3:0]     wb_sel_i,
  input  logic           wb_we_i,
  input  logic           wb_cyc_i,
  input  logic           wb_stb_i,
  output logic [DW-1:0]  wb_dat_o,
  output logic           wb_ack_o,
  output logic           wb_err_o,
  output logic           des_start_o,
  output logic           des_decrypt_o,
  output logic [191:0]   des_key_o,
  output logic [63:0]    des_data_o,
  input  logic           des_done_i,
  input  logic [63:0]    des_data_i,
  output logic           int_o
);

  localparam int WD_LIMIT = CORE_LAT + 16;
  localparam int WD_W     = $clog2(CORE_LAT + 17);

  state_t          state, state_nxt;
  logic [WD_W-1:0] wdog;
  logic [191:0]    key_q;
  logic [63:0]     din_q, dout_q;
  logic            decrypt_q, done_q, timeout_q;
  logic            req, busy, start_req, core_done, core_tmo;
  logic            wr_ctrl, wr_status, dec_err;
  logic [5:0]      wr_key;
  logic [1:0]      wr_din;
  logic [31:0]     wmask, rd_data, ctrl_rd, status_rd;
  logic            unused_adr;
`ifdef DES3_WB_REGS_INT_EN
  logic            ie_q;
`endif

  function automatic logic [31:0] merge_bytes(input logic [31:0] cur, input logic [31:0] wdat,
                                               input logic [31:0] mask);
    return (cur & ~mask) | (wdat & mask);
  endfunction

  assign req        = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
  assign busy       = (state == S_RUN);
  assign unused_adr = ^wb_adr_i[AW-1:4];
  assign start_req  = wr_ctrl & wmask[CTRL_START] & wb_dat_i[CTRL_START] & (state == S_IDLE);
  assign core_done  = busy & des_done_i;
  assign core_tmo   = busy & ~des_done_i & (wdog == WD_W'(WD_LIMIT));

  assign des_decrypt_o = decrypt_q;
  assign des_key_o     = key_q;
  assign des_data_o    = din_q;

  always_comb begin
    ctrl_rd                = '0;
    ctrl_rd[CTRL_DECRYPT]  = decrypt_q;
`ifdef DES3_WB_REGS_INT_EN
    ctrl_rd[CTRL_IE]       = ie_q;
`endif
    status_rd              = '0;
    status_rd[ST_BUSY]     = busy;
    status_rd[ST_DONE]     = done_q;
    status_rd[ST_TIMEOUT]  = timeout_q;
  end

  des3_wb_decode u_decode (
    .idx       (wb_adr_i[3:0]),
    .sel       (wb_sel_i),
    .req       (req),
    .we        (wb_we_i),
    .busy      (busy),
    .ctrl_rd   (ctrl_rd),
    .status_rd (status_rd),
    .key       (key_q),
    .din       (din_q),
    .dout      (dout_q),
    .wr_ctrl   (wr_ctrl),
    .wr_status (wr_status),
    .wr_key    (wr_key),
    .wr_din    (wr_din),
    .wmask     (wmask),
    .err       (dec_err),
    .rd_data   (rd_data)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_req) state_nxt = S_RUN;
      S_RUN:   if (core_done || core_tmo) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= S_IDLE;
      wdog        <= '0;
      wb_ack_o    <= 1'b0;
      wb_err_o    <= 1'b0;
      wb_dat_o    <= '0;
      des_start_o <= 1'b0;
    end else begin
      state       <= state_nxt;
      des_start_o <= start_req;
      wb_ack_o    <= req & ~dec_err;
      wb_err_o    <= req & dec_err;
      wb_dat_o    <= (req && !dec_err) ? rd_data : '0;
      // Saturating watchdog, restarted on every entry to RUN.
      if (start_req) wdog <= '0;
      else if (busy && wdog != '1) wdog <= wdog + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      key_q     <= '0;
      din_q     <= '0;
      dout_q    <= '0;
      decrypt_q <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
`ifdef DES3_WB_REGS_INT_EN
      ie_q      <= 1'b0;
`endif
    end else begin
      for (int i = 0; i < 6; i++)
        if (wr_key[i]) key_q[191-32*i -: 32] <= merge_bytes(key_q[191-32*i -: 32], wb_dat_i, wmask);
      for (int i = 0; i < 2; i++)
        if (wr_din[i]) din_q[63-32*i -: 32] <= merge_bytes(din_q[63-32*i -: 32], wb_dat_i, wmask);
      if (wr_ctrl && wmask[CTRL_DECRYPT]) decrypt_q <= wb_dat_i[CTRL_DECRYPT];
`ifdef DES3_WB_REGS_INT_EN
      if (wr_ctrl && wmask[CTRL_IE]) ie_q <= wb_dat_i[CTRL_IE];
`endif
      if (core_done) dout_q <= des_data_i;
      // Sticky flags: a hardware set in the same cycle wins over write-1-to-clear.
      if (wr_status && wmask[ST_DONE] && wb_dat_i[ST_DONE]) done_q <= 1'b0;
      if (core_done) done_q <= 1'b1;
      if (wr_status && wmask[ST_TIMEOUT] && wb_dat_i[ST_TIMEOUT]) timeout_q <= 1'b0;
      if (core_tmo) timeout_q <= 1'b1;
    end
  end

`ifdef DES3_WB_REGS_INT_EN
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) int_o <= 1'b0;
    else          int_o <= ie_q & (done_q | timeout_q);
  end
`else
  assign int_o = 1'b0;
`endif

endmodule

// File: tb/tb_des3_wb_regs.sv
// Directed self-checking bench for des3_wb_regs with a simple behavioural DES3 core model.
module tb_des3_wb_regs;

  localparam int AW = 30;
  localparam logic [63:0]  RESULT  = 64'h3FA40E8A_984D4815;
  localparam logic [191:0] KEY_EXP = {32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98,
                                      32'h76543210, 32'h0F1E2D3C, 32'h4B5A6978};
  localparam logic [63:0]  DIN_EXP = 64'h4E6F7720_69732074;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] wb_adr_i = '0;
  logic [31:0]   wb_dat_i = '0;
  logic [3:0]    wb_sel_i = '0;
  logic          wb_we_i = 1'b0, wb_cyc_i = 1'b0, wb_stb_i = 1'b0;
  logic [31:0]   wb_dat_o;
  logic          wb_ack_o, wb_err_o;
  logic          des_start_o, des_decrypt_o, int_o;
  logic [191:0]  des_key_o;
  logic [63:0]   des_data_o;
  logic          des_done_i = 1'b0;
  logic [63:0]   des_data_i = '0;

  int n_checks = 0;
  int n_fail   = 0;

  // Core model state
  int           start_cnt = 0;
  int           core_cnt = 0;
  bit           core_respond = 1'b0;
  bit           inject_done = 1'b0;
  logic [191:0] key_s = '0;
  logic [63:0]  data_s = '0;
  logic         decrypt_s = 1'b0;

  always #5 clk = ~clk;

  des3_wb_regs #(.AW(AW), .DW(32), .CORE_LAT(48)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .des_start_o(des_start_o), .des_decrypt_o(des_decrypt_o), .des_key_o(des_key_o),
    .des_data_o(des_data_o), .des_done_i(des_done_i), .des_data_i(des_data_i), .int_o(int_o)
  );

  // Core model: drives des_done_i on the falling edge so the DUT samples a stable pulse.
  always @(negedge clk) begin
    des_done_i = 1'b0;
    if (des_start_o) begin
      start_cnt++;
      key_s     = des_key_o;
      data_s    = des_data_o;
      decrypt_s = des_decrypt_o;
      if (core_respond) core_cnt = 48;
    end else if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0) begin
        des_done_i = 1'b1;
        des_data_i = RESULT;
      end
    end
    if (inject_done) begin
      des_done_i  = 1'b1;
      des_data_i  = 64'hDEADBEEF_CAFEF00D;
      inject_done = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete, checks=%0d", n_checks);
    $fatal(1, "bench timeout");
  end

  task automatic bus(input logic [3:0] idx, input logic we, input logic [31:0] wd,
                     input logic [3:0] sel, output logic [31:0] rd, output logic ack,
                     output logic err);
    int n = 0;
    wb_adr_i = AW'(idx);
    wb_we_i  = we;
    wb_dat_i = wd;
    wb_sel_i = sel;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!wb_ack_o && !wb_err_o && n < 8);
    ack = wb_ack_o;
    err = wb_err_o;
    rd  = wb_dat_o;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic ack, err;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (wb_ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", wb_ack_o); end
    n_checks++; if (wb_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", wb_err_o); end
    n_checks++; if (wb_dat_o !== 32'h0) begin n_fail++; $display("FAIL reset_dat: got %h want 0", wb_dat_o); end
    n_checks++; if (des_start_o !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b want 0", des_start_o); end
    n_checks++; if (int_o !== 1'b0) begin n_fail++; $display("FAIL reset_int: got %b want 0", int_o); end
    rst = 1'b0;
    @(posedge clk); #1;
    bus(4'd1, 1'b0, 32'h0, 4'hF, rd, ack, err);
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL reset_status_ack: got %b want 1", ack); end
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %h want 0", rd); end
  endtask

  task automatic test_encrypt();
    logic [31:0] keys [6] = '{32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98,
                              32'h76543210, 32'h0F1E2D3C, 32'h4B5A6978};
    logic [31:0] rd;
    logic ack, err, all_ack;
    bit finished;
    int start0;
    all_ack = 1'b1;
    core_respond = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus(4'(2 + i), 1'b1, keys[i], 4'hF, rd, ack, err);
      all_ack &= ack;
    end
    bus(4'd8, 1'b1, 32'h4E6F7720, 4'hF, rd, ack, err); all_ack &= ack;
    bus(4'd9, 1'b1, 32'h69732074, 4'hF, rd, ack, err); all_ack &= ack;
    n_checks++; if (all_ack !== 1'b1) begin n_fail++; $display("FAIL setup_acks: got %b want 1", all_ack); end
    start0 = start_cnt;
    bus(4'd0, 1'b1, 32'h1, 4'hF, rd, ack, err);
    // Write during RUN must be acknowledged and dropped.
    bus(4'd2, 1'b1, 32'hFFFFFFFF, 4'hF, rd, ack, err);
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL busy_write_ack: got %b want 1", ack); end
    finished = 1'b0;
    for (int i = 0; i < 60 && !finished; i++) begin
      bus(4'd1, 1'b0, 32'h0, 4'hF, rd, ack, err);
      if (rd[0] === 1'b0) finished = 1'b1;
    end
    n_checks++; if (finished !== 1'b1) begin n_fail++; $display("FAIL run_complete: busy stuck, got %b want 1", finished); end
    n_checks++; if (start_cnt - start0 !== 1) begin n_fail++; $display("FAIL start_pulses: got %0d want 1", start_cnt - start0); end
    n_checks++; if (key_s !== KEY_EXP) begin n_fail++; $display("FAIL start_key: got %h want %h", key_s, KEY_EXP); end
    n_checks++; if (data_s !== DIN_EXP) begin n_fail++; $display("FAIL start_data: got %h want %h", data_s, DIN_EXP); end
    n_checks++; if (decrypt_s !== 1'b0) begin n_fail++; $display("FAIL start_decrypt: got %b want 0", decrypt_s); end
    bus(4'd10, 1'b0, 32'h0, 4'hF, rd, ack, err);
    n_checks++; if (rd !== 32'h3FA40E8A) begin n_fail++; $display("FAIL dout_hi: got %h want 3fa40e8a", rd); end
    bus(4'd11, 1'b0, 32'h0, 4'hF, rd, ack, err);
    n_checks++; if (rd !== 32'h984D4815) begin n_fail++; $display("FAIL dout_lo: got %h want 984d4815", rd); end
    bus(4'd1, 1'b0, 32'h0, 4'hF, rd, ack, err);
    n_checks++; if (rd !== 32'h2) begin n_fail++; $display("FAIL status_done: got %h want 2", rd); end
    bus(4'd2, 1'b0, 32'h0, 4'hF, rd, ack, err);
    n_checks++; if (rd !== 32'h01234567) begin n_fail++; $display("FAIL busy_write_dropped: got %h want 01234567", rd); end
    n_checks++; if (int_o !== 1'b0) begin n_fail++; $display("FAIL int_ie_off: got %b want 0", int_o); end
    core_respond = 1'b0;
  endtask

  task automatic test_byte_sel();
    logic [31:0] rd;
    logic ack, err;
    bus(4'd2, 1'b1, 32'hAAAAAAAA, 4'h3, rd, ack, err);
    bus(4'd2, 1'b0, 32'h0, 4'hF, rd, ack, err);
    n_checks++; if (rd !== 32'h0123AAAA) begin n_fail++; $display("FAIL byte_sel_read: got %h want 0123aaaa", rd); end
    n_checks++; if (des_key_o[191:160] !== 32'h0123AAAA) begin n_fail++; $display("FAIL byte_sel_key: got %h want 0123aaaa", des_key_o[191:160]); end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic ack, err;
    bus(4'd13, 1'b0, 32'h0, 4'hF, rd, ack, err);
    n_checks++; if (err !== 1'b1 || ack !== 1'b0) begin n_fail++; $display("FAIL err_unmapped: got err=%b ack=%b want err=1 ack=0", err, ack); end
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL err_data: got %h want 0", rd); end
    n_checks++; if (wb_err_o !== 1'b0) begin n_fail++; $display("FAIL err_one_cycle: got %b want 0", wb_err_o); end
    bus(4'd10, 1'b1, 32'h12345678, 4'hF, rd, ack, err);
    n_checks++; if (err !== 1'b1 || ack !== 1'b0) begin n_fail++; $display("FAIL err_dout_write: got err=%b ack=%b want err=1 ack=0", err, ack); end
    bus(4'd10, 1'b0, 32'h0, 4'hF, rd, ack, err);
    n_checks++; if (ack !== 1'b1 || rd !== 32'h3FA40E8A) begin n_fail++; $display("FAIL err_no_change: got ack=%b %h want ack=1 3fa40e8a", ack, rd); end
  endtask

  task automatic test_timeout();
    logic [31:0] rd;
    logic ack, err;
    core_respond = 1'b0;
    bus(4'd1, 1'b1, 32'h2, 4'hF, rd, ack, err);
    bus(4'd1, 1'b0, 32'h0, 4'hF, rd, ack, err);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL done_w1c: got %h want 0", rd); end
    bus(4'd0, 1'b1, 32'h5, 4'hF, rd, ack, err);
    repeat (80) @(posedge clk);
    #1;
    bus(4'd1, 1'b0, 32'h0, 4'hF, rd, ack, err);
    n_checks++; if (rd !== 32'h4) begin n_fail++; $display("FAIL status_timeout: got %h want 4", rd); end
`ifdef DES3_WB_REGS_INT_EN
    n_checks++; if (int_o !== 1'b1) begin n_fail++; $display("FAIL int_timeout: got %b want 1", int_o); end
    bus(4'd0, 1'b0, 32'h0, 4'hF, rd, ack, err);
    n_checks++; if (rd !== 32'h4) begin n_fail++; $display("FAIL ctrl_read: got %h want 4", rd); end
`else
    n_checks++; if (int_o !== 1'b0) begin n_fail++; $display("FAIL int_disabled: got %b want 0", int_o); end
    bus(4'd0, 1'b0, 32'h0, 4'hF, rd, ack, err);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL ctrl_read: got %h want 0", rd); end
`endif
    bus(4'd11, 1'b0, 32'h0, 4'hF, rd, ack, err);
    n_checks++; if (rd !== 32'h984D4815) begin n_fail++; $display("FAIL timeout_dout_kept: got %h want 984d4815", rd); end
    bus(4'd1, 1'b1, 32'h4, 4'hF, rd, ack, err);
    bus(4'd1, 1'b0, 32'h0, 4'hF, rd, ack, err);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL timeout_w1c: got %h want 0", rd); end
    n_checks++; if (int_o !== 1'b0) begin n_fail++; $display("FAIL int_cleared: got %b want 0", int_o); end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] rd;
    logic ack, err;
    core_respond = 1'b0;
    bus(4'd0, 1'b1, 32'h1, 4'hF, rd, ack, err);
    bus(4'd1, 1'b0, 32'h0, 4'hF, rd, ack, err);
    n_checks++; if (rd !== 32'h1) begin n_fail++; $display("FAIL mid_run_busy: got %h want 1", rd); end
    repeat (4) @(posedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    inject_done = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus(4'd1, 1'b0, 32'h0, 4'hF, rd, ack, err);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rst_run_status: got %h want 0", rd); end
    bus(4'd10, 1'b0, 32'h0, 4'hF, rd, ack, err);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rst_run_dout_hi: got %h want 0", rd); end
    bus(4'd11, 1'b0, 32'h0, 4'hF, rd, ack, err);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rst_run_dout_lo: got %h want 0", rd); end
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_byte_sel();
    test_errors();
    test_timeout();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
